// File: rtl/bus_sw_ctrl.sv
// rtl/bus_sw_ctrl.sv - per-switch bus direction controller with break-before-make turnaround
//
// Purpose: drives NUM_SW independent bidirectional data bus switches. Each switch
//   is either off, enabled upstream, or enabled downstream. Any release of a
//   direction passes through TURN_CYC dead cycles before the next grant. A u/d
//   request collision while idle is reported on a shared one-cycle pulse. Switch 0
//   also carries a downstream bit mask.
//
// Optional feature: define BUS_SW_TURNAROUND_EN to build the TURN state and its
//   dead-cycle counter. Without it, switches move directly between OFF/UP/DN,
//   bus_sw_busy is tied low and TURN_CYC has no effect.
//
// Ports:
//   clk             - clock, all state on rising edge
//   nreset          - asynchronous active-low reset
//   ctl_sw_u        - [NUM_SW] per-switch upstream request
//   ctl_sw_d        - [NUM_SW] per-switch downstream request
//   ctl_sw_mask_en  - enable downstream masking on switch 0
//   ctl_sw_mask     - [DW] mask pattern, 1 forces the bit low downstream
//   bus_sw_u        - [NUM_SW] registered upstream enables
//   bus_sw_d        - [NUM_SW] registered downstream enables
//   bus_sw_mask     - [DW] effective mask for switch 0 downstream
//   bus_sw_busy     - [NUM_SW] switch is in turnaround
//   bus_sw_conflict - one-cycle pulse after a u/d collision is sampled

module bus_sw_ctrl #(
   parameter int NUM_SW   = 2,
   parameter int TURN_CYC = 1,
   parameter int DW       = 8
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic [NUM_SW-1:0] ctl_sw_u,
   input  logic [NUM_SW-1:0] ctl_sw_d,
   input  logic              ctl_sw_mask_en,
   input  logic [DW-1:0]     ctl_sw_mask,
   output logic [NUM_SW-1:0] bus_sw_u,
   output logic [NUM_SW-1:0] bus_sw_d,
   output logic [DW-1:0]     bus_sw_mask,
   output logic [NUM_SW-1:0] bus_sw_busy,
   output logic              bus_sw_conflict
);

   if (NUM_SW < 1 || NUM_SW > 8) begin : g_bad_num_sw
      $error("bus_sw_ctrl: NUM_SW must be 1..8");
   end
   if (TURN_CYC < 1 || TURN_CYC > 7) begin : g_bad_turn_cyc
      $error("bus_sw_ctrl: TURN_CYC must be 1..7");
   end

`ifdef BUS_SW_TURNAROUND_EN
   typedef enum logic [1:0] {ST_OFF = 2'd0, ST_UP = 2'd1, ST_DN = 2'd2, ST_TURN = 2'd3} sw_state_t;
   // Counter starts at TURN_CYC-1 so that TURN lasts exactly TURN_CYC cycles.
   localparam logic [2:0] TURN_LOAD = 3'(TURN_CYC - 1);
`else
   typedef enum logic [1:0] {ST_OFF = 2'd0, ST_UP = 2'd1, ST_DN = 2'd2} sw_state_t;
`endif

   // Grant decision for an idle switch: exactly one request wins, a collision stays off.
   function automatic sw_state_t off_next(input logic u, input logic d);
      if (u && !d) begin
         return ST_UP;
      end else if (d && !u) begin
         return ST_DN;
      end else begin
         return ST_OFF;
      end
   endfunction

   logic [NUM_SW-1:0] conf_vec;
   logic              conflict_q;
   logic [DW-1:0]     mask_q;

   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      sw_state_t state_q, state_d;
      logic      u, d, conf_d;

      assign u = ctl_sw_u[i];
      assign d = ctl_sw_d[i];

`ifdef BUS_SW_TURNAROUND_EN
      logic [2:0] cnt_q, cnt_d;

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         conf_d  = 1'b0;
         case (state_q)
            ST_OFF: begin
               state_d = off_next(u, d);
               conf_d  = u & d;
            end
            ST_UP: begin
               if (!(u && !d)) begin
                  state_d = ST_TURN;
                  cnt_d   = TURN_LOAD;
               end
            end
            ST_DN: begin
               if (!(d && !u)) begin
                  state_d = ST_TURN;
                  cnt_d   = TURN_LOAD;
               end
            end
            ST_TURN: begin
               // Requests are ignored until the last dead cycle, then treated as idle.
               if (cnt_q == 3'd0) begin
                  state_d = off_next(u, d);
                  conf_d  = u & d;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            default: state_d = ST_OFF;
         endcase
      end

      always_ff @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            state_q <= ST_OFF;
            cnt_q   <= 3'd0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      assign bus_sw_busy[i] = (state_q == ST_TURN);
`else
      // Every state re-arbitrates directly, so UP can swap to DN in one edge.
      always_comb begin
         state_d = off_next(u, d);
         conf_d  = u & d;
      end

      always_ff @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            state_q <= ST_OFF;
         end else begin
            state_q <= state_d;
         end
      end

      assign bus_sw_busy[i] = 1'b0;
`endif

      assign conf_vec[i] = conf_d;
      assign bus_sw_u[i] = (state_q == ST_UP);
      assign bus_sw_d[i] = (state_q == ST_DN);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         conflict_q <= 1'b0;
         mask_q     <= '0;
      end else begin
         conflict_q <= |conf_vec;
         mask_q     <= ctl_sw_mask_en ? ctl_sw_mask : '0;
      end
   end

   assign bus_sw_conflict = conflict_q;
   // Mask only takes effect while switch 0 actually drives downstream.
   assign bus_sw_mask     = mask_q & {DW{bus_sw_d[0]}};

endmodule

// File: tb/tb_bus_sw_ctrl.sv
// tb/tb_bus_sw_ctrl.sv - self-checking bench for bus_sw_ctrl

module tb_bus_sw_ctrl;

   localparam int NUM_SW   = 2;
   localparam int TURN_CYC = 2;
   localparam int DW       = 8;
`ifdef BUS_SW_TURNAROUND_EN
   localparam bit TURN_EN = 1'b1;
`else
   localparam bit TURN_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              nreset = 1'b0;
   logic [NUM_SW-1:0] ctl_sw_u = '0;
   logic [NUM_SW-1:0] ctl_sw_d = '0;
   logic              ctl_sw_mask_en = 1'b0;
   logic [DW-1:0]     ctl_sw_mask = '0;
   logic [NUM_SW-1:0] bus_sw_u;
   logic [NUM_SW-1:0] bus_sw_d;
   logic [DW-1:0]     bus_sw_mask;
   logic [NUM_SW-1:0] bus_sw_busy;
   logic              bus_sw_conflict;

   int checks = 0;
   int passed = 0;

   bus_sw_ctrl #(.NUM_SW(NUM_SW), .TURN_CYC(TURN_CYC), .DW(DW)) dut (
      .clk             (clk),
      .nreset          (nreset),
      .ctl_sw_u        (ctl_sw_u),
      .ctl_sw_d        (ctl_sw_d),
      .ctl_sw_mask_en  (ctl_sw_mask_en),
      .ctl_sw_mask     (ctl_sw_mask),
      .bus_sw_u        (bus_sw_u),
      .bus_sw_d        (bus_sw_d),
      .bus_sw_mask     (bus_sw_mask),
      .bus_sw_busy     (bus_sw_busy),
      .bus_sw_conflict (bus_sw_conflict)
   );

   always #5 clk = ~clk;

   // Reference model: who holds each switch (0 none, 1 up, 2 down) and how many
   // more edges the switch must sit out after a release.
   int            hold      [NUM_SW];
   int            wait_left [NUM_SW];
   logic          exp_conf;
   logic [DW-1:0] exp_mreg;

   task automatic model_reset();
      for (int i = 0; i < NUM_SW; i++) begin
         hold[i]      = 0;
         wait_left[i] = 0;
      end
      exp_conf = 1'b0;
      exp_mreg = '0;
   endtask

   task automatic model_edge(input logic [NUM_SW-1:0] u, input logic [NUM_SW-1:0] d,
                             input logic en, input logic [DW-1:0] m);
      logic c;
      c = 1'b0;
      if (!nreset) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NUM_SW; i++) begin
         bit fresh;
         if (wait_left[i] > 1) begin
            wait_left[i]--;
            continue;
         end
         fresh = (wait_left[i] == 1) || (hold[i] == 0);
         if (!fresh) begin
            if ((hold[i] == 1 && u[i] && !d[i]) || (hold[i] == 2 && d[i] && !u[i]))
               continue;
            if (TURN_EN) begin
               hold[i]      = 0;
               wait_left[i] = TURN_CYC;
               continue;
            end
         end
         wait_left[i] = 0;
         if (u[i] && d[i]) c = 1'b1;
         hold[i] = (u[i] && !d[i]) ? 1 : ((d[i] && !u[i]) ? 2 : 0);
      end
      exp_conf = c;
      exp_mreg = en ? m : '0;
   endtask

   function automatic logic [NUM_SW-1:0] exp_u();
      for (int i = 0; i < NUM_SW; i++) exp_u[i] = (hold[i] == 1);
   endfunction

   function automatic logic [NUM_SW-1:0] exp_d();
      for (int i = 0; i < NUM_SW; i++) exp_d[i] = (hold[i] == 2);
   endfunction

   function automatic logic [NUM_SW-1:0] exp_busy();
      for (int i = 0; i < NUM_SW; i++) exp_busy[i] = (wait_left[i] > 0);
   endfunction

   function automatic logic [DW-1:0] exp_mask();
      logic [NUM_SW-1:0] dv;
      dv = exp_d();
      return exp_mreg & {DW{dv[0]}};
   endfunction

   // Drive inputs away from the edge, take one rising edge, land on the next falling edge.
   task automatic step(input logic [NUM_SW-1:0] u, input logic [NUM_SW-1:0] d,
                       input logic en, input logic [DW-1:0] m);
      ctl_sw_u       = u;
      ctl_sw_d       = d;
      ctl_sw_mask_en = en;
      ctl_sw_mask    = m;
      @(posedge clk);
      model_edge(u, d, en, m);
      @(negedge clk);
   endtask

   task automatic test_reset();
      model_reset();
      step(2'b11, 2'b01, 1'b1, 8'hff);
      step(2'b01, 2'b10, 1'b1, 8'hff);
      checks++; if (bus_sw_u !== 2'b00) $display("FAIL reset_u got=%b exp=00", bus_sw_u); else passed++;
      checks++; if (bus_sw_d !== 2'b00) $display("FAIL reset_d got=%b exp=00", bus_sw_d); else passed++;
      checks++; if (bus_sw_busy !== 2'b00) $display("FAIL reset_busy got=%b exp=00", bus_sw_busy); else passed++;
      checks++; if (bus_sw_conflict !== 1'b0) $display("FAIL reset_conflict got=%b exp=0", bus_sw_conflict); else passed++;
      checks++; if (bus_sw_mask !== 8'h00) $display("FAIL reset_mask got=%h exp=00", bus_sw_mask); else passed++;
   endtask

   task automatic test_up_request();
      nreset = 1'b1;
      step(2'b01, 2'b00, 1'b0, 8'h00);
      checks++; if (bus_sw_u !== 2'b01) $display("FAIL up_u got=%b exp=01", bus_sw_u); else passed++;
      checks++; if (bus_sw_d !== 2'b00) $display("FAIL up_d got=%b exp=00", bus_sw_d); else passed++;
      checks++; if (bus_sw_busy !== 2'b00) $display("FAIL up_busy got=%b exp=00", bus_sw_busy); else passed++;
      checks++; if (bus_sw_conflict !== 1'b0) $display("FAIL up_conflict got=%b exp=0", bus_sw_conflict); else passed++;
      checks++; if (bus_sw_mask !== 8'h00) $display("FAIL up_mask got=%h exp=00", bus_sw_mask); else passed++;
      for (int e = 2; e <= 4; e++) begin
         step(2'b01, 2'b00, 1'b0, 8'h00);
         checks++; if (bus_sw_u !== 2'b01) $display("FAIL up_hold_e%0d got=%b exp=01", e, bus_sw_u); else passed++;
      end
   endtask

   task automatic test_up_to_dn();
      for (int e = 5; e <= 6; e++) begin
         step(2'b00, 2'b01, 1'b0, 8'h00);
         checks++; if (bus_sw_u !== 2'b00) $display("FAIL swap_u_e%0d got=%b exp=00", e, bus_sw_u); else passed++;
         checks++; if (bus_sw_d !== (TURN_EN ? 2'b00 : 2'b01))
            $display("FAIL swap_d_e%0d got=%b exp=%b", e, bus_sw_d, TURN_EN ? 2'b00 : 2'b01); else passed++;
         checks++; if (bus_sw_busy !== (TURN_EN ? 2'b01 : 2'b00))
            $display("FAIL swap_busy_e%0d got=%b exp=%b", e, bus_sw_busy, TURN_EN ? 2'b01 : 2'b00); else passed++;
      end
      step(2'b00, 2'b01, 1'b0, 8'h00);
      checks++; if (bus_sw_d !== 2'b01) $display("FAIL swap_d_e7 got=%b exp=01", bus_sw_d); else passed++;
      checks++; if (bus_sw_busy !== 2'b00) $display("FAIL swap_busy_e7 got=%b exp=00", bus_sw_busy); else passed++;
   endtask

   task automatic test_mask();
      step(2'b00, 2'b01, 1'b1, 8'h38);
      checks++; if (bus_sw_mask !== 8'h38) $display("FAIL mask_dn got=%h exp=38", bus_sw_mask); else passed++;
      step(2'b00, 2'b01, 1'b0, 8'h38);
      checks++; if (bus_sw_mask !== 8'h00) $display("FAIL mask_disabled got=%h exp=00", bus_sw_mask); else passed++;
      step(2'b00, 2'b01, 1'b1, 8'h38);
      checks++; if (bus_sw_mask !== 8'h38) $display("FAIL mask_reen got=%h exp=38", bus_sw_mask); else passed++;
      step(2'b00, 2'b00, 1'b1, 8'h38);
      checks++; if (bus_sw_d !== 2'b00) $display("FAIL mask_leave_d got=%b exp=00", bus_sw_d); else passed++;
      checks++; if (bus_sw_mask !== 8'h00) $display("FAIL mask_leave got=%h exp=00", bus_sw_mask); else passed++;
   endtask

   task automatic test_conflict();
      for (int k = 0; k < 4; k++) step(2'b00, 2'b00, 1'b0, 8'h00);
      step(2'b10, 2'b10, 1'b0, 8'h00);
      checks++; if (bus_sw_conflict !== 1'b1) $display("FAIL conflict_pulse got=%b exp=1", bus_sw_conflict); else passed++;
      checks++; if (bus_sw_u[1] !== 1'b0 || bus_sw_d[1] !== 1'b0)
         $display("FAIL conflict_outs got u=%b d=%b exp u=0 d=0", bus_sw_u[1], bus_sw_d[1]); else passed++;
      step(2'b00, 2'b00, 1'b0, 8'h00);
      checks++; if (bus_sw_conflict !== 1'b0) $display("FAIL conflict_end got=%b exp=0", bus_sw_conflict); else passed++;
      checks++; if (bus_sw_u[1] !== 1'b0 || bus_sw_d[1] !== 1'b0)
         $display("FAIL conflict_outs_after got u=%b d=%b exp u=0 d=0", bus_sw_u[1], bus_sw_d[1]); else passed++;
   endtask

   task automatic test_reset_mid_turn();
      step(2'b01, 2'b00, 1'b1, 8'h5a);
      step(2'b00, 2'b01, 1'b1, 8'h5a);
      checks++; if (bus_sw_busy !== (TURN_EN ? 2'b01 : 2'b00))
         $display("FAIL midturn_busy got=%b exp=%b", bus_sw_busy, TURN_EN ? 2'b01 : 2'b00); else passed++;
      #2 nreset = 1'b0;
      #1;
      checks++; if ({bus_sw_u, bus_sw_d, bus_sw_busy, bus_sw_conflict, bus_sw_mask} !== '0)
         $display("FAIL async_reset got u=%b d=%b busy=%b conf=%b mask=%h exp all zero",
                  bus_sw_u, bus_sw_d, bus_sw_busy, bus_sw_conflict, bus_sw_mask); else passed++;
      model_reset();
      @(negedge clk);
      nreset = 1'b1;
      step(2'b00, 2'b01, 1'b0, 8'h00);
      checks++; if (bus_sw_d !== 2'b01) $display("FAIL post_reset_d got=%b exp=01", bus_sw_d); else passed++;
      checks++; if (bus_sw_busy !== 2'b00) $display("FAIL post_reset_busy got=%b exp=00", bus_sw_busy); else passed++;
   endtask

   task automatic test_random();
      logic [NUM_SW-1:0] u, d;
      logic              en;
      logic [DW-1:0]     m;
      int                errs;
      u = '0; d = '0; en = 1'b0; m = '0; errs = 0;
      for (int c = 0; c < 400; c++) begin
         // Requests change only occasionally so switches dwell in UP/DN.
         for (int i = 0; i < NUM_SW; i++) begin
            if ($urandom_range(0, 3) == 0) u[i] = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) d[i] = $urandom_range(0, 1) == 1;
         end
         en = $urandom_range(0, 3) != 0;
         m  = DW'($urandom);
         nreset = ($urandom_range(0, 59) != 0);
         step(u, d, en, m);
         nreset = 1'b1;
         checks++;
         if (bus_sw_u !== exp_u() || bus_sw_d !== exp_d() || bus_sw_busy !== exp_busy() ||
             bus_sw_conflict !== exp_conf || bus_sw_mask !== exp_mask()) begin
            if (errs < 10)
               $display("FAIL random_c%0d got u=%b d=%b busy=%b conf=%b mask=%h exp u=%b d=%b busy=%b conf=%b mask=%h",
                        c, bus_sw_u, bus_sw_d, bus_sw_busy, bus_sw_conflict, bus_sw_mask,
                        exp_u(), exp_d(), exp_busy(), exp_conf, exp_mask());
            errs++;
         end else begin
            passed++;
         end
         checks++;
         if ((bus_sw_u & bus_sw_d) !== '0)
            $display("FAIL random_both_c%0d got u=%b d=%b exp disjoint", c, bus_sw_u, bus_sw_d);
         else
            passed++;
      end
   endtask

   initial begin
      test_reset();
      test_up_request();
      test_up_to_dn();
      test_mask();
      test_conflict();
      test_reset_mid_turn();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/bus_sw_ctrl.md
BUS_SW_CTRL -- requirements
Module: bus_sw_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SW, default 2, giving the number of independent data bus switches (1..8).
REQ-002 The block SHALL have parameter TURN_CYC, default 1, giving the dead cycles inserted on every switch release (1..7).
REQ-003 The block SHALL have parameter DW, default 8, giving the data bus width covered by the mask.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 The block SHALL have port nreset, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port ctl_sw_u, input, NUM_SW bits: per-switch upstream request.
REQ-007 The block SHALL have port ctl_sw_d, input, NUM_SW bits: per-switch downstream request.
REQ-008 The block SHALL have port ctl_sw_mask_en, input, 1 bit: enables downstream masking on switch 0.
REQ-009 The block SHALL have port ctl_sw_mask, input, DW bits: mask pattern, where 1 means bit forced low downstream.
REQ-010 The block SHALL have port bus_sw_u, output, NUM_SW bits: registered upstream enables.
REQ-011 The block SHALL have port bus_sw_d, output, NUM_SW bits: registered downstream enables.
REQ-012 The block SHALL have port bus_sw_mask, output, DW bits: effective mask applied to switch 0 downstream.
REQ-013 The block SHALL have port bus_sw_busy, output, NUM_SW bits: switch in turnaround.
REQ-014 The block SHALL have port bus_sw_conflict, output, 1 bit: one-cycle pulse when a u/d request conflict is sampled.

Function
REQ-015 Each switch SHALL run an independent FSM with states OFF, UP, DN and TURN, with a 3-bit turnaround counter.
REQ-016 From OFF: u-only SHALL go to UP, d-only SHALL go to DN, and none SHALL stay OFF.
REQ-017 From OFF: u and d together SHALL stay OFF and raise a conflict.
REQ-018 From UP: u-only SHALL stay UP. Any other request combination SHALL go to TURN, with the counter loaded to TURN_CYC-1.
REQ-019 From DN: d-only SHALL stay DN. Any other request combination SHALL go to TURN, with the counter loaded to TURN_CYC-1.
REQ-020 In TURN, the counter SHALL decrement each cycle and requests SHALL be ignored. At counter 0, the next state SHALL be evaluated with the OFF rules of REQ-016 and REQ-017 on the current requests.
REQ-021 The outputs SHALL be: bus_sw_u=1 only in UP, bus_sw_d=1 only in DN, and bus_sw_busy=1 only in TURN.
REQ-022 Outputs SHALL come from flops or from a decode of flops only, and SHALL never be combinational from the ctl_* inputs.
REQ-023 Latency SHALL be as follows: a request sampled at edge n SHALL be visible on the output after edge n.
REQ-024 Break-before-make SHALL hold: on any release, bus_sw_u and bus_sw_d of that switch SHALL both be low for exactly TURN_CYC cycles.
REQ-025 bus_sw_u[i] and bus_sw_d[i] SHALL never be high simultaneously.
REQ-026 bus_sw_conflict SHALL be registered. It SHALL be high for the cycle after any switch in OFF, or in TURN with counter 0, samples u and d together. It SHALL be an OR over all switches.
REQ-027 The mask register SHALL load ctl_sw_mask when ctl_sw_mask_en=1, and load 0 otherwise, every cycle.
REQ-028 bus_sw_mask SHALL equal the mask register AND-ed with bus_sw_d[0] replicated to DW bits.
REQ-029 Switches SHALL not interact, except through the shared conflict OR of REQ-026.

Reset
REQ-030 While nreset=0, all FSMs SHALL be in OFF and all counters SHALL be 0.
REQ-031 While nreset=0, the mask register SHALL be 0 and bus_sw_conflict SHALL be 0.
REQ-032 While nreset=0, every output SHALL be 0 immediately, without waiting for clk.
REQ-033 Reset asserted mid-UP, mid-DN or mid-TURN SHALL abort the state with no further dead cycles required.
REQ-034 The first edge after nreset deasserts SHALL apply the OFF rules.

Configuration
REQ-035 With macro BUS_SW_TURNAROUND_EN defined, the TURN state, counter and dead-cycle behaviour SHALL be as specified above.
REQ-036 Without BUS_SW_TURNAROUND_EN, the TURN state and counter SHALL be compiled out, and bus_sw_busy SHALL be tied to 0.
REQ-037 Without BUS_SW_TURNAROUND_EN, UP and DN SHALL apply the OFF rules directly. This allows an UP to DN swap in one edge, and the outputs SHALL still never be both high.
REQ-038 Without BUS_SW_TURNAROUND_EN, TURN_CYC SHALL be ignored.

Verification (NUM_SW=2, TURN_CYC=2, DW=8, macro defined unless stated)
REQ-039 Release nreset, then hold u[0]=1 from edge 1: bus_sw_u[0]=1 after edge 1, and every other output stays 0.
REQ-040 While in UP[0], switch to d[0]=1, u[0]=0 at edge 5: bus_sw_u[0]=0 and busy[0]=1 after edges 5 and 6; bus_sw_d[0]=1 after edge 7.
REQ-041 Apply u[1]=d[1]=1 from OFF: bus_sw_conflict pulses for one cycle, and bus_sw_u[1]=bus_sw_d[1]=0 throughout.
REQ-042 Apply mask_en=1 and mask=8'h38 with switch 0 in DN: bus_sw_mask=8'h38. After the switch leaves DN, bus_sw_mask=8'h00.
REQ-043 Assert nreset=0 mid-TURN between clock edges: all outputs go to 0 at once. After release with d[0]=1, bus_sw_d[0]=1 after the first edge.
REQ-044 With the macro undefined, repeat REQ-040: bus_sw_d[0]=1 after edge 5, and busy stays 0.
